// File: rtl/wb_regfile_sb.sv
// Architectural GPR file with a writeback valid/ready port, two bypassed read ports,
// and a per-register pending scoreboard used by decode for RAW/WAW interlocks.
module wb_regfile_sb #(
    parameter int NREG = 32,
    parameter int AW   = 5,
    parameter int DW   = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wb_valid_i,
    output logic          wb_ready_o,
    input  logic          wb_en_i,
    input  logic [AW-1:0] wb_addr_i,
    input  logic [DW-1:0] wb_data_i,
    input  logic          iss_valid_i,
    output logic          iss_ready_o,
    input  logic [AW-1:0] iss_rd_i,
    input  logic [AW-1:0] rs1_addr_i,
    output logic [DW-1:0] rs1_data_o,
    input  logic [AW-1:0] rs2_addr_i,
    output logic [DW-1:0] rs2_data_o,
    output logic          stall_o,
    output logic [AW:0]   pend_cnt_o,
    output logic          err_o
);

    logic [DW-1:0]   r_regs [NREG];
    logic [NREG-1:0] r_pend;
    logic [AW:0]     r_cnt;
    logic            r_err;

    logic w_wb_fire;
    logic w_wb_nz;
    logic w_wb_write;
    logic w_wb_clr;
    logic w_wb_bad;
    logic w_iss_set;

    assign wb_ready_o = !rst;
    assign w_wb_fire  = wb_valid_i && wb_ready_o;
    assign w_wb_nz    = w_wb_fire && (wb_addr_i != '0);
    assign w_wb_write = w_wb_nz && wb_en_i;
    assign w_wb_clr   = w_wb_nz && r_pend[wb_addr_i];
    assign w_wb_bad   = w_wb_nz && !r_pend[wb_addr_i];

    // A writeback retiring the same register this cycle frees it for re-issue.
    assign iss_ready_o = !rst && ((iss_rd_i == '0) || !r_pend[iss_rd_i] ||
                                  (w_wb_fire && (wb_addr_i == iss_rd_i)));
    assign w_iss_set   = iss_valid_i && iss_ready_o && (iss_rd_i != '0);

    function automatic logic [DW-1:0] read_port(input logic [AW-1:0] a);
        if (a == '0)
            return '0;
        else if (w_wb_write && (wb_addr_i == a))
            return wb_data_i;
        else
            return r_regs[a];
    endfunction

    function automatic logic src_blocked(input logic [AW-1:0] a);
        return (a != '0) && r_pend[a] && !(w_wb_fire && (wb_addr_i == a));
    endfunction

    assign rs1_data_o = read_port(rs1_addr_i);
    assign rs2_data_o = read_port(rs2_addr_i);
    assign stall_o    = src_blocked(rs1_addr_i) || src_blocked(rs2_addr_i);
    assign pend_cnt_o = r_cnt;
    assign err_o      = r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++)
                r_regs[i] <= '0;
            r_pend <= '0;
            r_cnt  <= '0;
            r_err  <= 1'b0;
        end else begin
            if (w_wb_write)
                r_regs[wb_addr_i] <= wb_data_i;
            if (w_wb_nz)
                r_pend[wb_addr_i] <= 1'b0;
            // Issue lands after the writeback clear, so a same-register pair stays pending.
            if (w_iss_set)
                r_pend[iss_rd_i] <= 1'b1;
            r_cnt <= r_cnt + (AW+1)'(w_iss_set) - (AW+1)'(w_wb_clr);
            if (w_wb_bad)
                r_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_wb_regfile_sb.sv
// Bench for wb_regfile_sb: directed scenarios followed by random traffic, all
// compared against an array-based model of the register file and scoreboard.
module tb_wb_regfile_sb;

    localparam int NREG = 32;
    localparam int AW   = 5;
    localparam int DW   = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          wb_valid_i;
    logic          wb_ready_o;
    logic          wb_en_i;
    logic [AW-1:0] wb_addr_i;
    logic [DW-1:0] wb_data_i;
    logic          iss_valid_i;
    logic          iss_ready_o;
    logic [AW-1:0] iss_rd_i;
    logic [AW-1:0] rs1_addr_i;
    logic [DW-1:0] rs1_data_o;
    logic [AW-1:0] rs2_addr_i;
    logic [DW-1:0] rs2_data_o;
    logic          stall_o;
    logic [AW:0]   pend_cnt_o;
    logic          err_o;

    int n_checks = 0;
    int n_errors = 0;

    logic [DW-1:0] m_regs [NREG];
    bit            m_pend [NREG];
    bit            m_err;

    wb_regfile_sb #(.NREG(NREG), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .wb_valid_i(wb_valid_i), .wb_ready_o(wb_ready_o), .wb_en_i(wb_en_i),
        .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i),
        .iss_valid_i(iss_valid_i), .iss_ready_o(iss_ready_o), .iss_rd_i(iss_rd_i),
        .rs1_addr_i(rs1_addr_i), .rs1_data_o(rs1_data_o),
        .rs2_addr_i(rs2_addr_i), .rs2_data_o(rs2_data_o),
        .stall_o(stall_o), .pend_cnt_o(pend_cnt_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] exp_read(input logic [AW-1:0] a);
        if (a == 0) return '0;
        if (!rst && wb_valid_i && wb_en_i && wb_addr_i == a) return wb_data_i;
        return m_regs[a];
    endfunction

    function automatic logic exp_blocked(input logic [AW-1:0] a);
        return a != 0 && m_pend[a] && !(!rst && wb_valid_i && wb_addr_i == a);
    endfunction

    function automatic int exp_count();
        int c = 0;
        for (int i = 0; i < NREG; i++) c += int'(m_pend[i]);
        return c;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NREG; i++) begin
            m_regs[i] = '0;
            m_pend[i] = 0;
        end
        m_err = 0;
    endtask

    task automatic idle();
        rst = 0; wb_valid_i = 0; wb_en_i = 0; wb_addr_i = '0; wb_data_i = '0;
        iss_valid_i = 0; iss_rd_i = '0; rs1_addr_i = '0; rs2_addr_i = '0;
    endtask

    // Check everything at the falling edge, advance the model, return just after the rising edge.
    task automatic cycle();
        bit exp_iss_rdy;
        @(negedge clk);
        exp_iss_rdy = !rst && (iss_rd_i == 0 || !m_pend[iss_rd_i] ||
                               (wb_valid_i && wb_addr_i == iss_rd_i));
        check("wb_ready", 32'(wb_ready_o), 32'(!rst));
        check("iss_ready", 32'(iss_ready_o), 32'(exp_iss_rdy));
        check("rs1_data", rs1_data_o, exp_read(rs1_addr_i));
        check("rs2_data", rs2_data_o, exp_read(rs2_addr_i));
        check("stall", 32'(stall_o), 32'(exp_blocked(rs1_addr_i) || exp_blocked(rs2_addr_i)));
        check("pend_cnt", 32'(pend_cnt_o), 32'(exp_count()));
        check("err", 32'(err_o), 32'(m_err));
        if (rst) begin
            model_reset();
        end else begin
            if (wb_valid_i && wb_addr_i != 0) begin
                if (wb_en_i) m_regs[wb_addr_i] = wb_data_i;
                if (!m_pend[wb_addr_i]) m_err = 1;
                m_pend[wb_addr_i] = 0;
            end
            if (iss_valid_i && exp_iss_rdy && iss_rd_i != 0) m_pend[iss_rd_i] = 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wb(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic en);
        wb_valid_i = 1; wb_addr_i = a; wb_data_i = d; wb_en_i = en;
    endtask

    initial begin
        idle();
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        model_reset();

        // Reset with preloaded registers
        cycle();
        rst = 0;
        for (int a = 1; a < NREG; a++) begin
            wb(AW'(a), $urandom, 1'b1);
            cycle();
        end
        idle();
        rst = 1;
        #3;
        check("rst_wb_ready", 32'(wb_ready_o), 32'd0);
        check("rst_iss_ready", 32'(iss_ready_o), 32'd0);
        cycle();
        rst = 0;
        #3;
        check("post_rst_wb_ready", 32'(wb_ready_o), 32'd1);
        check("post_rst_err", 32'(err_o), 32'd0);
        for (int a = 0; a < NREG; a++) begin
            rs1_addr_i = AW'(a);
            rs2_addr_i = AW'(NREG - 1 - a);
            cycle();
            check("post_rst_rs1", rs1_data_o, 32'd0);
        end

        // RAW on x5 resolved by bypass
        idle();
        iss_valid_i = 1; iss_rd_i = 5;
        cycle();
        idle();
        rs1_addr_i = 5;
        #3;
        check("x5_stall", 32'(stall_o), 32'd1);
        check("x5_cnt1", 32'(pend_cnt_o), 32'd1);
        cycle();
        wb(5, 32'hDEADBEEF, 1'b1);
        #3;
        check("x5_bypass", rs1_data_o, 32'hDEADBEEF);
        check("x5_unstall", 32'(stall_o), 32'd0);
        cycle();
        idle();
        rs1_addr_i = 5;
        #3;
        check("x5_cnt0", 32'(pend_cnt_o), 32'd0);
        check("x5_stored", rs1_data_o, 32'hDEADBEEF);
        cycle();

        // WAW on x7
        idle();
        iss_valid_i = 1; iss_rd_i = 7;
        cycle();
        #3;
        check("x7_blocked", 32'(iss_ready_o), 32'd0);
        cycle();
        #3;
        check("x7_cnt", 32'(pend_cnt_o), 32'd1);
        wb(7, 32'h0000_0777, 1'b1);
        #3;
        check("x7_same_cycle_ready", 32'(iss_ready_o), 32'd1);
        cycle();
        idle();
        #3;
        check("x7_still_pending", 32'(pend_cnt_o), 32'd1);
        wb(7, 32'h0000_0778, 1'b1);
        cycle();

        // Writeback to x0
        idle();
        wb(0, 32'h12345678, 1'b1);
        rs1_addr_i = 0;
        #3;
        check("x0_read", rs1_data_o, 32'd0);
        cycle();
        idle();
        #3;
        check("x0_err", 32'(err_o), 32'd0);
        check("x0_cnt", 32'(pend_cnt_o), 32'd0);
        cycle();

        // Stray writeback sets sticky error; en=0 writeback only clears pending
        iss_valid_i = 1; iss_rd_i = 3;
        cycle();
        idle();
        wb(3, 32'hAAAA0003, 1'b1);
        cycle();
        idle();
        iss_valid_i = 1; iss_rd_i = 3;
        cycle();
        idle();
        wb(9, 32'h0000_0099, 1'b1);
        cycle();
        idle();
        #3;
        check("err_set", 32'(err_o), 32'd1);
        wb(3, 32'h0BAD_0BAD, 1'b0);
        rs1_addr_i = 3;
        cycle();
        idle();
        rs1_addr_i = 3; rs2_addr_i = 9;
        #3;
        check("x3_kept", rs1_data_o, 32'hAAAA0003);
        check("x9_written", rs2_data_o, 32'h0000_0099);
        check("err_sticky", 32'(err_o), 32'd1);
        cycle();

        // Fill the scoreboard, then reset over a concurrent writeback
        idle();
        rst = 1;
        cycle();
        idle();
        for (int a = 1; a < NREG; a++) begin
            iss_valid_i = 1; iss_rd_i = AW'(a);
            cycle();
        end
        idle();
        #3;
        check("full_cnt", 32'(pend_cnt_o), 32'd31);
        rst = 1;
        wb(4, 32'hCAFE_0004, 1'b1);
        cycle();
        idle();
        #3;
        check("rst_cnt", 32'(pend_cnt_o), 32'd0);
        for (int a = 0; a < NREG; a++) begin
            rs1_addr_i = AW'(a);
            rs2_addr_i = AW'(a ^ 5);
            cycle();
        end

        // Random traffic concentrated on a few registers to provoke hazards
        for (int n = 0; n < 600; n++) begin
            rst         = ($urandom_range(0, 79) == 0);
            wb_valid_i  = $urandom_range(0, 1);
            wb_en_i     = ($urandom_range(0, 3) != 0);
            wb_addr_i   = AW'($urandom_range(0, 7));
            wb_data_i   = $urandom;
            iss_valid_i = $urandom_range(0, 1);
            iss_rd_i    = AW'($urandom_range(0, 7));
            rs1_addr_i  = AW'($urandom_range(0, 7));
            rs2_addr_i  = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
